// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : RV32I fetch stage: PC owner, single-outstanding imem requests,
//                redirect handling with stale-response squash and fault latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_fault,
    output logic        fault_pc_unused_guard,
    output logic [31:0] fault_pc
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_squash, w_squash_nxt;
    logic [31:0]  r_instr, w_instr_nxt;
    logic [31:0]  r_instr_pc, w_instr_pc_nxt;
    logic         r_fault, w_fault_nxt;
    logic [31:0]  r_fault_pc, w_fault_pc_nxt;
    logic         w_aligned;

    assign w_aligned = (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_squash   <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= 32'h0000_0000;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_squash   <= w_squash_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_fault    <= w_fault_nxt;
            r_fault_pc <= w_fault_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_squash_nxt   = r_squash;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_fault_nxt    = r_fault;
        w_fault_pc_nxt = r_fault_pc;

        if (r_state != ST_FAULT && redirect) begin
            if (!w_aligned) begin
                // PC is deliberately left alone so fault_pc is the only record
                w_state_nxt    = ST_FAULT;
                w_fault_nxt    = 1'b1;
                w_fault_pc_nxt = redirect_pc;
            end else begin
                w_pc_nxt = redirect_pc;
                case (r_state)
                    ST_WAIT: begin
                        // An in-flight response must still drain before refetching
                        if (imem_rvalid) begin
                            w_squash_nxt = 1'b0;
                            w_state_nxt  = ST_FETCH;
                        end else begin
                            w_squash_nxt = 1'b1;
                        end
                    end
                    ST_HOLD:  w_state_nxt = ST_FETCH;
                    default:  w_state_nxt = r_state;
                endcase
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_gnt) w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_squash) begin
                            w_squash_nxt = 1'b0;
                            w_state_nxt  = ST_FETCH;
                        end else begin
                            w_instr_nxt    = imem_rdata;
                            w_instr_pc_nxt = r_pc;
                            w_pc_nxt       = r_pc + 32'd4;
                            w_state_nxt    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) w_state_nxt = ST_FETCH;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign imem_req              = (r_state == ST_FETCH) && !redirect && !reset;
    assign imem_addr             = r_pc;
    assign instr_valid           = (r_state == ST_HOLD) && !reset;
    assign instr                 = r_instr;
    assign instr_pc              = r_instr_pc;
    assign fetch_fault           = r_fault;
    assign fault_pc              = r_fault_pc;
    assign fault_pc_unused_guard = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed and randomized self-checking bench for instr_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_fault;
    logic        guard;
    logic [31:0] fault_pc;

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk                   (clk),
        .reset                 (reset),
        .redirect              (redirect),
        .redirect_pc           (redirect_pc),
        .instr_ready           (instr_ready),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_gnt              (imem_gnt),
        .imem_rvalid           (imem_rvalid),
        .imem_rdata            (imem_rdata),
        .instr                 (instr),
        .instr_pc              (instr_pc),
        .instr_valid           (instr_valid),
        .fetch_fault           (fetch_fault),
        .fault_pc_unused_guard (guard),
        .fault_pc              (fault_pc)
    );

    always #5 clk = ~clk;

    // Reference model: tracks what the fetch stage is doing in transaction terms
    logic        m_dead, m_outstanding, m_stale, m_presenting;
    logic [31:0] m_pc, m_instr, m_ipc, m_fault_pc;

    always @(posedge clk) begin
        if (reset) begin
            m_dead <= 1'b0; m_outstanding <= 1'b0; m_stale <= 1'b0; m_presenting <= 1'b0;
            m_pc <= 32'h0; m_instr <= 32'h0000_0013; m_ipc <= 32'h0; m_fault_pc <= 32'h0;
        end else if (m_dead) begin
            m_dead <= 1'b1;
        end else if (redirect && redirect_pc[1:0] != 2'b00) begin
            m_dead     <= 1'b1;
            m_fault_pc <= redirect_pc;
        end else if (redirect) begin
            if (m_outstanding) begin
                m_outstanding <= !imem_rvalid;
                m_stale       <= !imem_rvalid;
            end
            m_presenting <= 1'b0;
            m_pc         <= redirect_pc;
        end else if (m_outstanding) begin
            if (imem_rvalid) begin
                m_outstanding <= 1'b0;
                m_stale       <= 1'b0;
                if (!m_stale) begin
                    m_presenting <= 1'b1;
                    m_instr      <= imem_rdata;
                    m_ipc        <= m_pc;
                    m_pc         <= m_pc + 32'd4;
                end
            end
        end else if (m_presenting) begin
            if (instr_ready) m_presenting <= 1'b0;
        end else if (imem_gnt) begin
            m_outstanding <= 1'b1;
        end
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);
        total += 6;
        if (imem_req !== 1'b0)       begin bad++; $display("FAIL rst_req got=%h exp=0", imem_req); end
        if (instr_valid !== 1'b0)    begin bad++; $display("FAIL rst_valid got=%h exp=0", instr_valid); end
        if (instr !== 32'h13)        begin bad++; $display("FAIL rst_instr got=%h exp=00000013", instr); end
        if (instr_pc !== 32'h0)      begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
        if (fetch_fault !== 1'b0)    begin bad++; $display("FAIL rst_fault got=%h exp=0", fetch_fault); end
        if (fault_pc !== 32'h0)      begin bad++; $display("FAIL rst_fault_pc got=%h exp=0", fault_pc); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total += 2;
        if (imem_req !== 1'b1)       begin bad++; $display("FAIL first_req got=%h exp=1", imem_req); end
        if (imem_addr !== 32'h0)     begin bad++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_basic();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        @(negedge clk);
        total += 2;
        if (imem_req !== 1'b0)       begin bad++; $display("FAIL basic_wait_req got=%h exp=0", imem_req); end
        if (instr_valid !== 1'b0)    begin bad++; $display("FAIL basic_wait_valid got=%h exp=0", instr_valid); end
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        total += 3;
        if (instr_valid !== 1'b1)        begin bad++; $display("FAIL basic_valid got=%h exp=1", instr_valid); end
        if (instr !== 32'h0050_0093)     begin bad++; $display("FAIL basic_instr got=%h exp=00500093", instr); end
        if (instr_pc !== 32'h0)          begin bad++; $display("FAIL basic_instr_pc got=%h exp=0", instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        total += 2;
        if (imem_req !== 1'b1)       begin bad++; $display("FAIL basic_next_req got=%h exp=1", imem_req); end
        if (imem_addr !== 32'h4)     begin bad++; $display("FAIL basic_next_addr got=%h exp=4", imem_addr); end
    endtask

    task automatic test_hold_stall();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
        tick();
        imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total += 4;
            if (instr_valid !== 1'b1)    begin bad++; $display("FAIL stall_valid[%0d] got=%h exp=1", i, instr_valid); end
            if (instr !== 32'h0010_0113) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=00100113", i, instr); end
            if (instr_pc !== 32'h4)      begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=4", i, instr_pc); end
            if (imem_req !== 1'b0)       begin bad++; $display("FAIL stall_req[%0d] got=%h exp=0", i, imem_req); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        total += 2;
        if (imem_req !== 1'b1)       begin bad++; $display("FAIL stall_next_req got=%h exp=1", imem_req); end
        if (imem_addr !== 32'h8)     begin bad++; $display("FAIL stall_next_addr got=%h exp=8", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        total += 1;
        if (imem_req !== 1'b0)       begin bad++; $display("FAIL rdw_req got=%h exp=0", imem_req); end
        tick();
        redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        total += 3;
        if (instr_valid !== 1'b0)    begin bad++; $display("FAIL rdw_squash_valid got=%h exp=0", instr_valid); end
        if (imem_req !== 1'b1)       begin bad++; $display("FAIL rdw_req_after got=%h exp=1", imem_req); end
        if (imem_addr !== 32'h100)   begin bad++; $display("FAIL rdw_addr got=%h exp=100", imem_addr); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        total += 1;
        if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0073;
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        total += 2;
        if (instr_valid !== 1'b1)        begin bad++; $display("FAIL wrap_valid got=%h exp=1", instr_valid); end
        if (instr_pc !== 32'hFFFF_FFFC)  begin bad++; $display("FAIL wrap_instr_pc got=%h exp=fffffffc", instr_pc); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        total += 1;
        if (imem_addr !== 32'h0)     begin bad++; $display("FAIL wrap_next_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_fault();
        redirect = 1'b1; redirect_pc = 32'h102;
        tick();
        for (int i = 0; i < 6; i++) begin
            redirect    = $urandom_range(0, 1) == 1;
            redirect_pc = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            imem_gnt    = $urandom_range(0, 1) == 1;
            imem_rvalid = $urandom_range(0, 1) == 1;
            instr_ready = $urandom_range(0, 1) == 1;
            imem_rdata  = $urandom();
            @(negedge clk);
            total += 4;
            if (fetch_fault !== 1'b1)    begin bad++; $display("FAIL fault_flag[%0d] got=%h exp=1", i, fetch_fault); end
            if (fault_pc !== 32'h102)    begin bad++; $display("FAIL fault_pc[%0d] got=%h exp=102", i, fault_pc); end
            if (imem_req !== 1'b0)       begin bad++; $display("FAIL fault_req[%0d] got=%h exp=0", i, imem_req); end
            if (instr_valid !== 1'b0)    begin bad++; $display("FAIL fault_valid[%0d] got=%h exp=0", i, instr_valid); end
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        total += 4;
        if (fetch_fault !== 1'b0)    begin bad++; $display("FAIL fault_clear got=%h exp=0", fetch_fault); end
        if (fault_pc !== 32'h0)      begin bad++; $display("FAIL fault_pc_clear got=%h exp=0", fault_pc); end
        if (imem_req !== 1'b1)       begin bad++; $display("FAIL fault_rst_req got=%h exp=1", imem_req); end
        if (imem_addr !== 32'h0)     begin bad++; $display("FAIL fault_rst_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        @(negedge clk);
        total += 1;
        if (imem_req !== 1'b0)       begin bad++; $display("FAIL riw_wait_req got=%h exp=0", imem_req); end
        reset = 1'b1;
        tick();
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        total += 3;
        if (imem_req !== 1'b1)       begin bad++; $display("FAIL riw_req got=%h exp=1", imem_req); end
        if (imem_addr !== 32'h0)     begin bad++; $display("FAIL riw_addr got=%h exp=0", imem_addr); end
        if (instr_valid !== 1'b0)    begin bad++; $display("FAIL riw_valid got=%h exp=0", instr_valid); end
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        total += 2;
        if (instr_valid !== 1'b0)    begin bad++; $display("FAIL riw_valid2 got=%h exp=0", instr_valid); end
        if (imem_addr !== 32'h0)     begin bad++; $display("FAIL riw_addr2 got=%h exp=0", imem_addr); end
    endtask

    task automatic test_random();
        logic        pend, fire_req, fire_rsp, exp_req, exp_valid;
        logic [31:0] pend_addr, req_addr;
        int          pend_dly, dead_cnt;
        pend = 1'b0; pend_addr = 32'h0; pend_dly = 0; dead_cnt = 0;
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset       = ($urandom_range(0, 199) == 0) || (dead_cnt >= 4);
            redirect    = $urandom_range(0, 99) < 12;
            case ($urandom_range(0, 15))
                0:       redirect_pc = $urandom() | 32'h1;
                1:       redirect_pc = 32'hFFFF_FFFC;
                default: redirect_pc = $urandom() & 32'h0000_FFFC;
            endcase
            instr_ready = $urandom_range(0, 2) != 0;
            imem_gnt    = $urandom_range(0, 2) != 0;
            imem_rvalid = pend && (pend_dly == 0);
            imem_rdata  = imem_rvalid ? mem_word(pend_addr) : $urandom();
            @(negedge clk);
            exp_req   = !m_dead && !m_outstanding && !m_presenting && !redirect && !reset;
            exp_valid = m_presenting && !m_dead && !reset;
            total += 7;
            if (imem_req !== exp_req)       begin bad++; $display("FAIL rnd_req c%0d got=%h exp=%h", cyc, imem_req, exp_req); end
            if (imem_addr !== m_pc)         begin bad++; $display("FAIL rnd_addr c%0d got=%h exp=%h", cyc, imem_addr, m_pc); end
            if (instr_valid !== exp_valid)  begin bad++; $display("FAIL rnd_valid c%0d got=%h exp=%h", cyc, instr_valid, exp_valid); end
            if (instr !== m_instr)          begin bad++; $display("FAIL rnd_instr c%0d got=%h exp=%h", cyc, instr, m_instr); end
            if (instr_pc !== m_ipc)         begin bad++; $display("FAIL rnd_instr_pc c%0d got=%h exp=%h", cyc, instr_pc, m_ipc); end
            if (fetch_fault !== m_dead)     begin bad++; $display("FAIL rnd_fault c%0d got=%h exp=%h", cyc, fetch_fault, m_dead); end
            if (fault_pc !== m_fault_pc)    begin bad++; $display("FAIL rnd_fault_pc c%0d got=%h exp=%h", cyc, fault_pc, m_fault_pc); end
            fire_req = imem_req && imem_gnt;
            fire_rsp = imem_rvalid;
            req_addr = imem_addr;
            dead_cnt = m_dead ? dead_cnt + 1 : 0;
            tick();
            if (fire_rsp) pend = 1'b0;
            else if (pend && pend_dly > 0) pend_dly--;
            if (fire_req) begin
                pend      = 1'b1;
                pend_addr = req_addr;
                pend_dly  = $urandom_range(0, 2);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_redirect_wait();
        test_wrap();
        test_fault();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the single-cycle RV32I core: it owns the program counter and issues word requests to instruction memory. It returns each fetched word on `instr` with a valid/ready handshake, and it honours control-flow redirects from the core (branch/jump target). At most one memory request is outstanding at a time. Responses made stale by a redirect are squashed, and a misaligned redirect target latches a fault.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `redirect` input, 1 bit: load `redirect_pc` as the next fetch address this cycle.
- `redirect_pc` input, 32 bits: redirect target.
- `instr_ready` input, 1 bit: core accepts `instr` this cycle.
- `imem_req` output, 1 bit: request valid.
- `imem_addr` output, 32 bits: byte address of the word requested; always the PC register.
- `imem_gnt` input, 1 bit: memory accepts the request this cycle.
- `imem_rvalid` input, 1 bit: response data valid.
- `imem_rdata` input, 32 bits: response word.
- `instr` output, 32 bits: fetched instruction.
- `instr_pc` output, 32 bits: address of `instr`.
- `instr_valid` output, 1 bit: `instr`/`instr_pc` valid.
- `fetch_fault` output, 1 bit: sticky misaligned-redirect flag.
- `fault_pc` output, 32 bits: offending redirect target.

## Operation
- Registers: `pc`, `state`, `squash`, `instr`, `instr_pc`, `fetch_fault`, `fault_pc`.
- States:
  - FETCH: request.
  - WAIT: awaiting response.
  - HOLD: presenting instruction.
  - FAULT: terminal.
- `imem_req = (state==FETCH) && !redirect && !reset`. `instr_valid = (state==HOLD)`.
- Redirect has priority over all events except reset. It is evaluated in every non-FAULT state.
  - If `redirect_pc[1:0] != 0`: go to FAULT, set `fetch_fault`, and set `fault_pc <= redirect_pc`. The PC is unchanged.
- FETCH:
  - Aligned redirect: `pc <= redirect_pc`, stay in FETCH.
  - Else `imem_gnt`: go to WAIT.
  - Else stay.
- WAIT:
  - Redirect without `imem_rvalid`: `pc <= redirect_pc`, `squash <= 1`, stay in WAIT.
  - Redirect with `imem_rvalid`: discard the data, `pc <= redirect_pc`, `squash <= 0`, go to FETCH.
  - `imem_rvalid` with `squash`: discard the data, `squash <= 0`, go to FETCH.
  - `imem_rvalid`, not squashed: `instr <= imem_rdata`, `instr_pc <= pc`, `pc <= pc + 4`, go to HOLD.
- HOLD:
  - Aligned redirect: drop the held instruction, `pc <= redirect_pc`, go to FETCH.
  - Else `instr_ready`: go to FETCH.
  - Else hold. `instr` and `instr_pc` stay stable while `instr_valid=1`.
- FAULT:
  - `imem_req=0`, `instr_valid=0`.
  - All inputs are ignored; only reset exits.
- `imem_rvalid` in FETCH, HOLD or FAULT is a protocol violation and is ignored; this covers stale responses after reset.
- `pc + 4` wraps modulo 2^32. There is no other arithmetic.

## Timing
- Reset values:
  - `pc=RESET_PC`, `state=FETCH`, `squash=0`.
  - `instr=32'h0000_0013` (NOP), `instr_pc=0`.
  - `fetch_fault=0`, `fault_pc=0`.
  - `instr_valid=0`, `imem_req=0` while reset is high.
- First `imem_req=1` occurs in the first cycle after reset deasserts, with `imem_addr=RESET_PC`.
- Reset mid-operation (any state) restores all reset values on the next edge. Any outstanding response is then ignored.
- Latency, with zero-wait memory (gnt in FETCH, rvalid the next cycle):
  - grant edge to WAIT, response edge to HOLD.
  - `instr_valid` rises 2 cycles after `imem_req` first asserts.
- Throughput with `instr_ready` tied high: 1 instruction per 3 cycles (FETCH, WAIT, HOLD).
- A redirect seen at edge N produces `imem_addr=redirect_pc` in cycle N+1 (from FETCH/HOLD). From WAIT it appears after the squashed response retires.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (FETCH, WAIT, HOLD, FAULT);
  - `NOP_INSTR = 32'h0000_0013`;
  - `DEFAULT_RESET_PC`.
- Single module, no sub-modules. The next-PC mux and FSM are inline.

## Test plan
- Reset, then gnt at once and rvalid next cycle with `rdata=32'h0050_0093` → `instr_valid=1`, `instr=32'h0050_0093`, `instr_pc=0`; after `instr_ready`, `imem_addr=4`.
- `instr_ready` held low 5 cycles in HOLD → `instr` and `instr_pc` stable, `imem_req=0` throughout; the next request fires the cycle after ready.
- Redirect to `0x100` in WAIT, then rvalid with `0xDEADBEEF` → no `instr_valid` for `0xDEADBEEF`; the next request has `imem_addr=0x100`.
- Redirect to `0x102` → `fetch_fault=1`, `fault_pc=0x102`, `imem_req=0` for all following cycles until reset; reset clears the fault.
- Redirect to `0xFFFF_FFFC`, complete the fetch → `instr_pc=0xFFFF_FFFC`, next `imem_addr=0`.
- Reset asserted in WAIT, stale rvalid in the first post-reset cycle → ignored; `imem_addr=RESET_PC`, `instr_valid=0`.
